// File: rtl/restoring_divider.sv
// restoring_divider: multi-cycle unsigned divider, radix-2 restoring
// algorithm retiring one quotient bit per clock.
// Operands arrive on an in_valid/in_ready handshake and results leave on an
// out_valid/out_ready handshake; a transfer happens on a rising edge where
// both valid and ready are high, and valid holds its payload until then.
// Only one division is in flight at a time.
// Optional build macro SIGNED_DIV_EN: operands and results are two's
// complement with truncating (C-style) semantics; latency is unchanged.
module restoring_divider #(
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] dividend,
    input  logic [WORD_WIDTH-1:0] divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] quotient,
    output logic [WORD_WIDTH-1:0] remainder,
    output logic                  div_by_zero,
    output logic [1:0]            state_dbg
);

    localparam int W  = WORD_WIDTH;
    localparam int CW = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WORD_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    div_r;     // latched divisor (magnitude in signed builds)
    logic [W-1:0]    q_r;       // dividend shifts out the top, quotient bits in the bottom
    logic [W-1:0]    r_r;       // partial remainder, always < divisor so W bits suffice
    logic [CW-1:0]   cnt;       // iteration counter

    // W+1-bit working remainder and trial subtraction for this iteration
    logic [W:0]      r_shift;
    logic [W:0]      trial;
    logic [W-1:0]    q_step;
    logic [W-1:0]    r_step;
    logic [W-1:0]    q_final;
    logic [W-1:0]    r_final;
    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;

`ifdef SIGNED_DIV_EN
    logic            neg_q;     // operand signs differed
    logic            neg_r;     // dividend was negative
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero divisor skips straight to DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == LAST_ITER) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // One restoring step plus operand/result sign handling
    always_comb begin
        r_shift = {1'b0, r_r[W-1:0]} << 1;
        r_shift[0] = q_r[W-1];
        trial   = r_shift - {1'b0, div_r};
        if (trial[W]) begin
            // Trial went negative: keep the shifted remainder, quotient bit 0
            r_step = r_shift[W-1:0];
            q_step = {q_r[W-2:0], 1'b0};
        end else begin
            r_step = trial[W-1:0];
            q_step = {q_r[W-2:0], 1'b1};
        end
`ifdef SIGNED_DIV_EN
        // Magnitude of the most negative value is 2^(W-1), which fits unsigned
        mag_a   = dividend[W-1] ? (~dividend + 1'b1) : dividend;
        mag_b   = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
        q_final = neg_q ? (~q_step + 1'b1) : q_step;
        r_final = neg_r ? (~r_step + 1'b1) : r_step;
`else
        mag_a   = dividend;
        mag_b   = divisor;
        q_final = q_step;
        r_final = r_step;
`endif
    end

    // Datapath registers: load on accept, iterate in CALC, publish on entry to DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r       <= '0;
            q_r         <= '0;
            r_r         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        div_r <= mag_b;
                        q_r   <= mag_a;
                        r_r   <= '0;
                        cnt   <= '0;
`ifdef SIGNED_DIV_EN
                        neg_q <= dividend[W-1] ^ divisor[W-1];
                        neg_r <= dividend[W-1];
`endif
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    q_r <= q_step;
                    r_r <= r_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        quotient    <= q_final;
                        remainder   <= r_final;
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
